distrib_reader: RTL

//  Read-side engine for the distributed-RAM frame buffer in the udp_ip path.
//  - Accepts a descriptor (start address, length) for a frame already written into the RAM.
//  - Drives the RAM's asynchronous read address and streams the frame out as one word per

---
 rtl/udp_ip_pkg.sv | 20 ++
 rtl/distrib_reader_csum16_acc.sv | 69 ++++++
 rtl/distrib_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/udp_ip_pkg.sv
// Shared types and helpers for the udp_ip read path.
// Holds the reader FSM state type and the ones-complement adder used by
// the optional checksum accumulator (DISTRIB_READER_CSUM_EN).
package udp_ip_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  // 16-bit ones-complement add with end-around carry. After folding the
  // carry back in, the result cannot overflow again: a carry out implies
  // the low 16 bits are at most 0xFFFE.
  function automatic logic [15:0] csum16_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/distrib_reader_csum16_acc.sv
// csum16_acc: pairs a byte stream big-endian into 16-bit words and keeps a
// ones-complement running sum. clear_i restarts the sum. final_i latches
// the inverted sum, including a zero-padded odd trailing byte, onto csum_o.
// csum_o holds its value until the next final_i.
module csum16_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  input  logic        final_i,
  output logic [15:0] csum_o
);
  import udp_ip_pkg::*;

  logic [15:0] sum_q, sum_d;
  logic [7:0]  hi_q, hi_d;
  logic        odd_q, odd_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] fin_s;

  // Next-state for the pairing register, the running sum and the finalized checksum.
  always_comb begin
    sum_d  = sum_q;
    hi_d   = hi_q;
    odd_d  = odd_q;
    csum_d = csum_q;
    fin_s  = odd_q ? csum16_add(sum_q, {hi_q, 8'h00}) : sum_q;
    if (clear_i) begin
      sum_d = 16'h0000;
      hi_d  = 8'h00;
      odd_d = 1'b0;
    end else if (load_i) begin
      if (odd_q) begin
        sum_d = csum16_add(sum_q, {hi_q, byte_i});
        odd_d = 1'b0;
      end else begin
        hi_d  = byte_i;
        odd_d = 1'b1;
      end
    end else begin
      sum_d = sum_q;
    end
    // An empty frame clears and finishes on the same edge; its sum is zero.
    if (final_i) begin
      csum_d = clear_i ? 16'hFFFF : ~fin_s;
    end else begin
      csum_d = csum_q;
    end
  end

  // Accumulator and checksum registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 16'h0000;
      hi_q   <= 8'h00;
      odd_q  <= 1'b0;
      csum_q <= 16'h0000;
    end else begin
      sum_q  <= sum_d;
      hi_q   <= hi_d;
      odd_q  <= odd_d;
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;

endmodule

// File: rtl/distrib_reader.sv
// distrib_reader: read engine for the distributed-RAM frame buffer.
// Takes a (start address, length) descriptor and streams that many words out
// of the ring one word per cycle on a valid/ready port. m_last marks the final
// word, and done pulses once for each accepted descriptor.
// Optional feature macro: DISTRIB_READER_CSUM_EN adds the csum output, an
// IP-style ones-complement checksum of the frame bytes. It requires WIDTH == 8.
module distrib_reader #(
  parameter int ORDER = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ORDER-1:0] req_addr,
  input  logic [ORDER:0]   req_len,
  output logic [ORDER-1:0] rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             done
`ifdef DISTRIB_READER_CSUM_EN
  ,
  output logic [15:0]      csum
`endif
);
  import udp_ip_pkg::*;

  rd_state_t        state_q, state_d;
  logic [ORDER-1:0] ptr_q, ptr_d;
  logic [ORDER:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             done_q, done_d;

  // Descriptor intake, word loading and frame completion.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ptr_d = req_addr;
          cnt_d = req_len;
          if (req_len != {(ORDER+1){1'b0}}) begin
            state_d = STREAM;
          end else begin
            // An empty frame completes without producing any beat.
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if ((!m_valid_q || m_ready) && (cnt_q != {(ORDER+1){1'b0}})) begin
          m_data_d  = rd_data;
          m_valid_d = 1'b1;
          m_last_d  = (cnt_q == (ORDER+1)'(1));
          ptr_d     = ptr_q + ORDER'(1);  // wraps around the ring
          cnt_d     = cnt_q - (ORDER+1)'(1);
        end else if ((cnt_q == {(ORDER+1){1'b0}}) && m_valid_q && m_ready && m_last_q) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = STREAM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer/count and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= {ORDER{1'b0}};
      cnt_q     <= {(ORDER+1){1'b0}};
      m_data_q  <= {WIDTH{1'b0}};
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rd_addr   = ptr_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign done      = done_q;

`ifdef DISTRIB_READER_CSUM_EN
  logic accept_s;
  logic load_s;

  assign accept_s = req_valid & req_ready;
  assign load_s   = (state_q == STREAM) & (!m_valid_q | m_ready) & (cnt_q != {(ORDER+1){1'b0}});

  csum16_acc u_csum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept_s),
    .load_i  (load_s),
    .byte_i  (rd_data[7:0]),
    .final_i (done_d),
    .csum_o  (csum)
  );
`endif

endmodule
